spi_frame_loader: RTL and testbench

- Upstream of the LED-matrix display driver.
- Receives pixel data from the host MCU over a mode-0 SPI slave link, oversampled in the `clk` domain.
- Packs one byte per pixel and issues sequential write strobes into the display framebuffer.
- Signals completion of each full frame so the display side can latch or swap buffers.

---
 rtl/panel_pkg.sv | 12 +
 rtl/spi_frame_loader_if.sv | 17 +
 rtl/spi_sync.sv | 38 +++
 rtl/spi_frame_loader.sv | 100 ++++++++++
 tb/tb_spi_frame_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/panel_pkg.sv
// panel_pkg: panel geometry, pixel/address types and receiver states
// shared by the SPI frame loader and the display driver's read side.
package panel_pkg;
    localparam int PANEL_W    = 64;
    localparam int PANEL_H    = 64;
    localparam int COLOR_BITS = 3;
    localparam int NUM_PIX    = PANEL_W * PANEL_H;
    localparam int ADDR_W     = $clog2(NUM_PIX);
    typedef logic [COLOR_BITS-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]     addr_t;
    typedef enum logic {IDLE, SHIFT} rx_state_t;
endpackage

// File: rtl/spi_frame_loader_if.sv
// spi_frame_loader_if: host SPI pins plus framebuffer write port of the loader.
interface spi_frame_loader_if #(
    parameter int ADDR_W     = panel_pkg::ADDR_W,
    parameter int COLOR_BITS = panel_pkg::COLOR_BITS
);
    logic                  sclk;
    logic                  sdi;
    logic                  ce;
    logic                  sdo;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [COLOR_BITS-1:0] wr_data;
    logic                  frame_done;
    logic                  busy;
    modport slave  (input sclk, sdi, ce, output sdo, wr_en, wr_addr, wr_data, frame_done, busy);
    modport master (output sclk, sdi, ce, input sdo, wr_en, wr_addr, wr_data, frame_done, busy);
endinterface

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizers for sclk/sdi/ce with sclk and ce edge detection
// in the clk domain.
module spi_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sclk,
    input  logic i_sdi,
    input  logic i_ce,
    output logic o_sdi,
    output logic o_ce,
    output logic o_rise,
    output logic o_fall,
    output logic o_ce_rise,
    output logic o_ce_fall
);
    logic [2:0] r_sclk;
    logic [1:0] r_sdi;
    logic [2:0] r_ce;
    // ce stages reset high so a transaction already running at reset release
    // never looks like a fresh ce rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk <= '0;
            r_sdi  <= '0;
            r_ce   <= '1;
        end else begin
            r_sclk <= {r_sclk[1:0], i_sclk};
            r_sdi  <= {r_sdi[0], i_sdi};
            r_ce   <= {r_ce[1:0], i_ce};
        end
    end
    assign o_sdi     = r_sdi[1];
    assign o_ce      = r_ce[1];
    assign o_rise    = r_sclk[1] & ~r_sclk[2];
    assign o_fall    = ~r_sclk[1] & r_sclk[2];
    assign o_ce_rise = r_ce[1] & ~r_ce[2];
    assign o_ce_fall = ~r_ce[1] & r_ce[2];
endmodule

// File: rtl/spi_frame_loader.sv
// spi_frame_loader: mode-0 SPI slave that packs one byte per pixel into row-major
// framebuffer writes, echoes the previous byte on sdo and flags each full frame.
module spi_frame_loader #(
    parameter int PANEL_W    = panel_pkg::PANEL_W,
    parameter int PANEL_H    = panel_pkg::PANEL_H,
    parameter int COLOR_BITS = panel_pkg::COLOR_BITS
) (
    input logic               clk,
    input logic               reset_n,
    spi_frame_loader_if.slave bus
);
    localparam int NUM_PIX = PANEL_W * PANEL_H;
    localparam int ADDR_W  = $clog2(NUM_PIX);
    logic w_sdi, w_ce, w_rise, w_fall, w_ce_rise, w_ce_fall, w_last;
    logic [7:0] w_byte;
    panel_pkg::rx_state_t  r_state;
    logic [2:0]            r_cnt;
    logic [7:0]            r_shift, r_echo, r_sdo_sh;
    logic [ADDR_W-1:0]     r_addr, r_wr_addr;
    logic [COLOR_BITS-1:0] r_wr_data;
    logic                  r_armed, r_wr_en, r_frame_done, r_busy, r_sdo;
    spi_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_sclk    (bus.sclk),
        .i_sdi     (bus.sdi),
        .i_ce      (bus.ce),
        .o_sdi     (w_sdi),
        .o_ce      (w_ce),
        .o_rise    (w_rise),
        .o_fall    (w_fall),
        .o_ce_rise (w_ce_rise),
        .o_ce_fall (w_ce_fall)
    );
    assign w_byte = {r_shift[6:0], w_sdi};
    assign w_last = r_addr == ADDR_W'(NUM_PIX - 1);
    // r_sdo_sh holds the bits still to be presented; it reloads with the byte just
    // received so its MSB goes out on the fall that ends that byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= panel_pkg::IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_echo       <= '0;
            r_sdo_sh     <= '0;
            r_addr       <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_armed      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_sdo        <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_armed      <= r_armed | ~w_ce;
            if (r_state == panel_pkg::IDLE) begin
                r_sdo  <= 1'b0;
                r_busy <= 1'b0;
                if (w_ce_rise && r_armed) begin
                    r_state  <= panel_pkg::SHIFT;
                    r_busy   <= 1'b1;
                    r_cnt    <= '0;
                    r_addr   <= '0;
                    r_sdo    <= r_echo[7];
                    r_sdo_sh <= {r_echo[6:0], 1'b0};
                end
            end else if (w_ce_fall) begin
                r_state <= panel_pkg::IDLE;
                r_busy  <= 1'b0;
                r_sdo   <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_shift <= w_byte;
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= r_addr;
                        r_wr_data    <= w_byte[COLOR_BITS-1:0];
                        r_frame_done <= w_last;
                        r_echo       <= w_byte;
                        r_sdo_sh     <= w_byte;
                        r_addr       <= w_last ? '0 : r_addr + 1'b1;
                    end
                end
                if (w_fall) begin
                    r_sdo    <= r_sdo_sh[7];
                    r_sdo_sh <= {r_sdo_sh[6:0], 1'b0};
                end
            end
        end
    end
    assign bus.sdo        = r_sdo;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_spi_frame_loader.sv
// tb_spi_frame_loader: randomized SPI host driving the loader, checked against a
// queue-based model of expected pixel writes and sdo echo bytes.
module tb_spi_frame_loader;
    localparam int PW   = 16;
    localparam int PH   = 16;
    localparam int CB   = 3;
    localparam int NP   = PW * PH;
    localparam int AW   = $clog2(NP);
    localparam int HALF = 4;
    typedef struct packed {
        logic          fd;
        logic [AW-1:0] a;
        logic [CB-1:0] d;
    } wr_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int last_rise_cyc = 0;
    int stray_fd = 0;
    wr_t exp_q[$];
    wr_t act_q[$];
    bit active = 1'b0;
    int m_addr = 0;
    logic [7:0] m_echo = 8'h00;
    spi_frame_loader_if #(.ADDR_W(AW), .COLOR_BITS(CB)) bus ();
    spi_frame_loader #(.PANEL_W(PW), .PANEL_H(PH), .COLOR_BITS(CB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.wr_en) begin
                act_q.push_back('{fd: bus.frame_done, a: bus.wr_addr, d: bus.wr_data});
                wr_cyc = cyc;
            end else if (bus.frame_done) begin
                stray_fd++;
            end
        end
    end
    task automatic model_byte(input logic [7:0] b);
        if (active) begin
            exp_q.push_back('{fd: (m_addr == NP - 1), a: AW'(m_addr), d: b[CB-1:0]});
            m_addr = (m_addr + 1) % NP;
            m_echo = b;
        end
    endtask
    task automatic drive_bit(input logic b, output logic m);
        bus.sdi = b;
        repeat (HALF) @(negedge clk);
        m = bus.sdo;
        bus.sclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (HALF) @(negedge clk);
        bus.sclk = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b, input string nm);
        logic [7:0] m;
        logic [7:0] want;
        want = active ? m_echo : 8'h00;
        for (int i = 7; i >= 0; i--) drive_bit(b[i], m[i]);
        checks++;
        if (m !== want) begin
            fails++;
            $display("FAIL %s sdo echo got %h want %h", nm, m, want);
        end
        model_byte(b);
    endtask
    task automatic ce_on();
        bus.ce = 1'b1;
        repeat (4) @(negedge clk);
        active = 1'b1;
        m_addr = 0;
    endtask
    task automatic ce_off();
        repeat (4) @(negedge clk);
        bus.ce = 1'b0;
        repeat (6) @(negedge clk);
    endtask
    task automatic check_writes(input string nm);
        checks++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s write count got %0d want %0d", nm, act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s write %0d got fd=%b a=%0d d=%0d want fd=%b a=%0d d=%0d", nm, i,
                         act_q[i].fd, act_q[i].a, act_q[i].d, exp_q[i].fd, exp_q[i].a, exp_q[i].d);
            end
        end
        checks++;
        if (stray_fd != 0) begin
            fails++;
            $display("FAIL %s frame_done without wr_en got %0d want 0", nm, stray_fd);
        end
        act_q.delete();
        exp_q.delete();
        stray_fd = 0;
    endtask
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checks += 6;
        if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL reset wr_en got %b want 0", bus.wr_en); end
        if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset frame_done got %b want 0", bus.frame_done); end
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", bus.busy); end
        if (bus.sdo !== 1'b0) begin fails++; $display("FAIL reset sdo got %b want 0", bus.sdo); end
        if (bus.wr_addr !== '0) begin fails++; $display("FAIL reset wr_addr got %0d want 0", bus.wr_addr); end
        if (bus.wr_data !== '0) begin fails++; $display("FAIL reset wr_data got %0d want 0", bus.wr_data); end
        check_writes("reset");
    endtask
    task automatic test_single();
        ce_on();
        checks++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL single busy got %b want 1", bus.busy); end
        send_byte(8'hA5, "single");
        ce_off();
        checks++;
        if (wr_cyc - last_rise_cyc != 3) begin
            fails++;
            $display("FAIL single latency got %0d want 3", wr_cyc - last_rise_cyc);
        end
        checks++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL single busy_after got %b want 0", bus.busy); end
        check_writes("single");
    endtask
    task automatic test_multi();
        ce_on();
        send_byte(8'h01, "multi");
        send_byte(8'h02, "multi");
        send_byte(8'h03, "multi");
        ce_off();
        check_writes("multi");
    endtask
    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            ce_on();
            for (int k = 0, n = $urandom_range(1, 12); k < n; k++) send_byte(8'($urandom), "random");
            ce_off();
            check_writes("random");
        end
    endtask
    task automatic test_frame();
        ce_on();
        for (int i = 0; i < NP; i++) send_byte(8'(i & 7), "frame");
        send_byte(8'h06, "frame");
        ce_off();
        check_writes("frame");
    endtask
    task automatic test_partial();
        logic m;
        ce_on();
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom), m);
        ce_off();
        check_writes("partial");
        ce_on();
        send_byte(8'h07, "after_partial");
        ce_off();
        check_writes("after_partial");
    endtask
    task automatic test_reset_mid();
        logic m;
        ce_on();
        send_byte(8'($urandom), "pre_reset");
        send_byte(8'($urandom), "pre_reset");
        for (int i = 0; i < 4; i++) drive_bit(1'($urandom), m);
        repeat (6) @(negedge clk);
        check_writes("pre_reset");
        reset_n = 1'b0;
        active = 1'b0;
        m_echo = 8'h00;
        #2;
        checks++;
        if (bus.wr_addr !== '0) begin fails++; $display("FAIL reset_mid wr_addr got %0d want 0", bus.wr_addr); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'($urandom), "ignored");
        send_byte(8'($urandom), "ignored");
        checks++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignored busy got %b want 0", bus.busy); end
        ce_off();
        check_writes("ignored");
        ce_on();
        send_byte(8'($urandom), "rearmed");
        ce_off();
        check_writes("rearmed");
    endtask
    initial begin
        bus.sclk = 1'b0;
        bus.sdi = 1'b0;
        bus.ce = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_random();
        test_frame();
        test_partial();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
